// File: rtl/qr_locate_sequencer.sv
// qr_locate_sequencer: per-frame controller for the finder-pattern locate
// pipeline. Resets the finders, runs the horizontal/vertical scanners, then
// the cross finder, orders the three finder centres into corner / top-right /
// bottom-left and reports them, or flags a failure when the cycle budget runs out.
// Optional feature: define LOCATE_STATS_EN to add saturating ok/fail/drop
// counters with a synchronous clear.
module qr_locate_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned COORD_W        = 9
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 frame_ready,
  input  logic                 abort_in,
  input  logic                 horz_done,
  input  logic                 vert_done,
  input  logic                 centers_valid,
  input  logic [3*COORD_W-1:0] centers_x,
  input  logic [3*COORD_W-1:0] centers_y,
  output logic                 finder_rst,
  output logic                 start_horz,
  output logic                 start_vert,
  output logic                 start_cross,
  output logic                 busy,
  output logic                 locate_valid,
  output logic                 locate_fail,
  output logic [COORD_W-1:0]   corner_x,
  output logic [COORD_W-1:0]   corner_y,
  output logic [COORD_W-1:0]   right_x,
  output logic [COORD_W-1:0]   right_y,
  output logic [COORD_W-1:0]   bottom_x,
  output logic [COORD_W-1:0]   bottom_y
`ifdef LOCATE_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [15:0]          stat_ok,
  output logic [15:0]          stat_fail,
  output logic [15:0]          stat_drop
`endif
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PREP, SCAN, CROSS, SORT, DONE, FAIL} state_t;

  state_t             state;
  logic [TW-1:0]      timer;
  logic               horz_l, vert_l;
  logic [COORD_W-1:0] cap_x [0:2];
  logic [COORD_W-1:0] cap_y [0:2];

  logic [COORD_W:0]   d01, d02, d12;
  logic [1:0]         crn, pa, pb, rgt, btm;
  logic               both_done;

  function automatic logic [COORD_W:0] manh(input logic [COORD_W-1:0] ax,
                                            input logic [COORD_W-1:0] ay,
                                            input logic [COORD_W-1:0] bx,
                                            input logic [COORD_W-1:0] by);
    logic [COORD_W-1:0] dx, dy;
    dx = (ax > bx) ? ax - bx : bx - ax;
    dy = (ay > by) ? ay - by : by - ay;
    return {1'b0, dx} + {1'b0, dy};
  endfunction

  assign busy      = (state != IDLE);
  assign both_done = (horz_l | horz_done) & (vert_l | vert_done);

  // Order the captured centres: the longest side's endpoints are right/bottom,
  // the remaining index is the corner.
  always_comb begin
    d01 = manh(cap_x[0], cap_y[0], cap_x[1], cap_y[1]);
    d02 = manh(cap_x[0], cap_y[0], cap_x[2], cap_y[2]);
    d12 = manh(cap_x[1], cap_y[1], cap_x[2], cap_y[2]);
    if (d12 >= d02 && d12 >= d01) begin
      crn = 2'd0; pa = 2'd1; pb = 2'd2;
    end else if (d02 >= d01) begin
      crn = 2'd1; pa = 2'd0; pb = 2'd2;
    end else begin
      crn = 2'd2; pa = 2'd0; pb = 2'd1;
    end
    // pa is always the lower index, so keeping pa on a full tie picks the lower index
    if (cap_y[pb] < cap_y[pa] || (cap_y[pb] == cap_y[pa] && cap_x[pb] < cap_x[pa])) begin
      rgt = pb; btm = pa;
    end else begin
      rgt = pa; btm = pb;
    end
  end

  // Sequencer FSM with registered control pulses, timer, done latches and capture.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state        <= IDLE;
      timer        <= '0;
      horz_l       <= 1'b0;
      vert_l       <= 1'b0;
      finder_rst   <= 1'b0;
      start_horz   <= 1'b0;
      start_vert   <= 1'b0;
      start_cross  <= 1'b0;
      locate_valid <= 1'b0;
      locate_fail  <= 1'b0;
      corner_x     <= '0;
      corner_y     <= '0;
      right_x      <= '0;
      right_y      <= '0;
      bottom_x     <= '0;
      bottom_y     <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        cap_x[i] <= '0;
        cap_y[i] <= '0;
      end
    end else begin
      finder_rst   <= 1'b0;
      start_horz   <= 1'b0;
      start_vert   <= 1'b0;
      start_cross  <= 1'b0;
      locate_valid <= 1'b0;
      locate_fail  <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_ready) begin
            state      <= PREP;
            finder_rst <= 1'b1;
          end
        end
        PREP: begin
          horz_l <= 1'b0;
          vert_l <= 1'b0;
          timer  <= '0;
          if (abort_in) begin
            state      <= IDLE;
            finder_rst <= 1'b1;
          end else begin
            state      <= SCAN;
            start_horz <= 1'b1;
            start_vert <= 1'b1;
          end
        end
        SCAN: begin
          timer  <= timer + 1'b1;
          horz_l <= horz_l | horz_done;
          vert_l <= vert_l | vert_done;
          if (abort_in) begin
            state      <= IDLE;
            finder_rst <= 1'b1;
          end else if (both_done) begin
            state       <= CROSS;
            start_cross <= 1'b1;
          end else if (timer == TIMER_LAST) begin
            state       <= FAIL;
            locate_fail <= 1'b1;
            finder_rst  <= 1'b1;
          end
        end
        CROSS: begin
          timer <= timer + 1'b1;
          if (abort_in) begin
            state      <= IDLE;
            finder_rst <= 1'b1;
          end else if (centers_valid) begin
            state <= SORT;
            for (int unsigned i = 0; i < 3; i++) begin
              cap_x[i] <= centers_x[i*COORD_W +: COORD_W];
              cap_y[i] <= centers_y[i*COORD_W +: COORD_W];
            end
          end else if (timer == TIMER_LAST) begin
            state       <= FAIL;
            locate_fail <= 1'b1;
            finder_rst  <= 1'b1;
          end
        end
        SORT: begin
          corner_x     <= cap_x[crn];
          corner_y     <= cap_y[crn];
          right_x      <= cap_x[rgt];
          right_y      <= cap_y[rgt];
          bottom_x     <= cap_x[btm];
          bottom_y     <= cap_y[btm];
          locate_valid <= 1'b1;
          state        <= DONE;
        end
        DONE:    state <= IDLE;
        FAIL:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOCATE_STATS_EN
  // Saturating event counters; a clear in the same cycle as an event wins.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stat_ok   <= '0;
      stat_fail <= '0;
      stat_drop <= '0;
    end else if (stat_clr) begin
      stat_ok   <= '0;
      stat_fail <= '0;
      stat_drop <= '0;
    end else begin
      if (locate_valid && stat_ok != '1)        stat_ok   <= stat_ok + 16'd1;
      if (locate_fail && stat_fail != '1)       stat_fail <= stat_fail + 16'd1;
      if (frame_ready && busy && stat_drop != '1) stat_drop <= stat_drop + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qr_locate_sequencer.sv
// Scoreboard bench for qr_locate_sequencer (TIMEOUT_CYCLES=20): stimulus pushes
// the expected locate result, a monitor pops it on each locate_valid/locate_fail.
module tb_qr_locate_sequencer;

  localparam int unsigned CW = 9;

  logic            clk_in = 1'b0;
  logic            rst_in = 1'b0;
  logic            frame_ready = 1'b0, abort_in = 1'b0;
  logic            horz_done = 1'b0, vert_done = 1'b0, centers_valid = 1'b0;
  logic [3*CW-1:0] centers_x = '0, centers_y = '0;
  logic            finder_rst, start_horz, start_vert, start_cross, busy;
  logic            locate_valid, locate_fail;
  logic [CW-1:0]   corner_x, corner_y, right_x, right_y, bottom_x, bottom_y;
`ifdef LOCATE_STATS_EN
  logic            stat_clr = 1'b0;
  logic [15:0]     stat_ok, stat_fail, stat_drop;
`endif

  qr_locate_sequencer #(.TIMEOUT_CYCLES(20), .COORD_W(CW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_ready(frame_ready), .abort_in(abort_in),
    .horz_done(horz_done), .vert_done(vert_done), .centers_valid(centers_valid),
    .centers_x(centers_x), .centers_y(centers_y),
    .finder_rst(finder_rst), .start_horz(start_horz), .start_vert(start_vert),
    .start_cross(start_cross), .busy(busy), .locate_valid(locate_valid),
    .locate_fail(locate_fail),
    .corner_x(corner_x), .corner_y(corner_y), .right_x(right_x), .right_y(right_y),
    .bottom_x(bottom_x), .bottom_y(bottom_y)
`ifdef LOCATE_STATS_EN
    , .stat_clr(stat_clr), .stat_ok(stat_ok), .stat_fail(stat_fail), .stat_drop(stat_drop)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit          fail;
    logic [53:0] coords;  // {cx, cy, rx, ry, bx, by}
  } exp_t;

  exp_t        sb[$];
  logic [53:0] last_ok = '0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3*CW-1:0] pk(input int a, input int b, input int c);
    return {CW'(c), CW'(b), CW'(a)};
  endfunction

  function automatic logic [53:0] xy6(input int cx, input int cy, input int rx,
                                      input int ry, input int bx, input int by);
    return {CW'(cx), CW'(cy), CW'(rx), CW'(ry), CW'(bx), CW'(by)};
  endfunction

  // Monitor: every result pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (rst_in && (locate_valid || locate_fail)) begin
        if (sb.size() == 0) begin
          chk("unexpected_result_pulse", {locate_valid, locate_fail}, 2'b00);
        end else begin
          e = sb.pop_front();
          chk("result_kind", {locate_valid, locate_fail}, e.fail ? 2'b01 : 2'b10);
          chk("result_coords", {corner_x, corner_y, right_x, right_y, bottom_x, bottom_y},
              e.coords);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Ends positioned in the first SCAN cycle (cycle 0).
  task automatic start_frame();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("prep_finder_rst", {finder_rst, busy, start_horz}, 3'b110);
    tick();
    chk("scan_start", {start_horz, start_vert, finder_rst}, 3'b110);
  endtask

  // Pulse dones at the given SCAN cycles; ends in the first CROSS cycle.
  task automatic scan_dones(input int h_at, input int v_at);
    int last;
    last = (h_at > v_at) ? h_at : v_at;
    for (int c = 0; c <= last; c++) begin
      horz_done = (c == h_at);
      vert_done = (c == v_at);
      tick();
    end
    horz_done = 1'b0;
    vert_done = 1'b0;
    chk("cross_start", {start_cross, start_horz, start_vert}, 3'b100);
  endtask

  task automatic finish_cross(input logic [3*CW-1:0] xs, input logic [3*CW-1:0] ys,
                              input logic [53:0] exp_coords);
    exp_t e;
    e.fail = 1'b0;
    e.coords = exp_coords;
    sb.push_back(e);
    last_ok = exp_coords;
    centers_x = xs;
    centers_y = ys;
    centers_valid = 1'b1;
    tick();
    centers_valid = 1'b0;
    chk("sort_no_pulse", {locate_valid, locate_fail}, 2'b00);
    tick();
    chk("done_valid_latency", locate_valid, 1'b1);
    tick();
    chk("back_to_idle", {busy, locate_valid}, 2'b00);
  endtask

  initial begin
    exp_t e;
    // Reset state
    #1;
    chk("reset_outputs", {finder_rst, start_horz, start_vert, start_cross, busy,
                          locate_valid, locate_fail, corner_x, corner_y, right_x,
                          right_y, bottom_x, bottom_y}, '0);
    tick();
    tick();
    rst_in = 1'b1;
    tick();
    // Inputs other than frame_ready have no effect in IDLE
    abort_in = 1'b1; horz_done = 1'b1; vert_done = 1'b1; centers_valid = 1'b1;
    tick();
    abort_in = 1'b0; horz_done = 1'b0; vert_done = 1'b0; centers_valid = 1'b0;
    chk("idle_ignores", {busy, finder_rst, start_horz}, 3'b000);

    // Nominal flow
    start_frame();
    scan_dones(5, 9);
    finish_cross(pk(100, 300, 100), pk(100, 100, 300), xy6(100, 100, 300, 100, 100, 300));

    // Ordering: corner is idx1
    start_frame();
    scan_dones(3, 1);
    finish_cross(pk(50, 50, 250), pk(250, 50, 50), xy6(50, 50, 250, 50, 50, 250));

    // Ordering: corner is idx2 (d01 longest)
    start_frame();
    scan_dones(2, 2);
    finish_cross(pk(0, 200, 200), pk(0, 200, 0), xy6(200, 0, 0, 0, 200, 200));

    // Equal y on the far pair: smaller x becomes right
    start_frame();
    scan_dones(1, 4);
    finish_cross(pk(150, 300, 0), pk(10, 100, 100), xy6(150, 10, 0, 100, 300, 100));

    // All three coincident
    start_frame();
    scan_dones(0, 6);
    finish_cross(pk(10, 10, 10), pk(10, 10, 10), xy6(10, 10, 10, 10, 10, 10));

    // Timeout: vert_done never arrives; fail 20 cycles after SCAN entry
    start_frame();
    horz_done = 1'b1;
    tick();
    horz_done = 1'b0;
    e.fail = 1'b1;
    e.coords = last_ok;
    sb.push_back(e);
    repeat (18) tick();
    chk("fail_not_early", locate_fail, 1'b0);
    tick();
    chk("fail_pulse_rst", {locate_fail, finder_rst}, 2'b11);
    chk("fail_coords_held", {corner_x, corner_y, right_x, right_y, bottom_x, bottom_y},
        xy6(10, 10, 10, 10, 10, 10));
    tick();
    chk("fail_to_idle", {busy, locate_fail}, 2'b00);

    // Dones with the start pulses, centers_valid on the last budget cycle
    start_frame();
    scan_dones(0, 0);
    repeat (18) tick();
    finish_cross(pk(100, 300, 100), pk(100, 100, 300), xy6(100, 100, 300, 100, 100, 300));

    // frame_ready during CROSS is dropped
    start_frame();
    scan_dones(2, 3);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("drop_no_rst", finder_rst, 1'b0);
    finish_cross(pk(50, 50, 250), pk(250, 50, 50), xy6(50, 50, 250, 50, 50, 250));
    repeat (3) tick();
    chk("drop_not_queued", busy, 1'b0);
`ifdef LOCATE_STATS_EN
    chk("stat_drop", stat_drop, 16'd1);
    chk("stat_fail", stat_fail, 16'd1);
    chk("stat_ok", stat_ok, 16'd7);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("stat_clr", {stat_ok, stat_fail, stat_drop}, '0);
`endif

    // Abort in CROSS
    start_frame();
    scan_dones(0, 0);
    abort_in = 1'b1;
    tick();
    abort_in = 1'b0;
    chk("abort_idle_rst", {busy, finder_rst, locate_fail}, 3'b010);
    tick();
    chk("abort_rst_single", finder_rst, 1'b0);

    // Reset mid-SCAN, then a normal frame
    start_frame();
    tick();
    tick();
    rst_in = 1'b0;
    #1;
    chk("midreset_outputs", {finder_rst, start_horz, start_vert, start_cross, busy,
                             locate_valid, locate_fail, corner_x, corner_y, right_x,
                             right_y, bottom_x, bottom_y}, '0);
    last_ok = '0;
    tick();
    rst_in = 1'b1;
    tick();
    start_frame();
    scan_dones(4, 2);
    finish_cross(pk(0, 200, 200), pk(0, 200, 0), xy6(200, 0, 0, 0, 200, 200));

    repeat (3) tick();
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/qr_locate_sequencer.md
Name: qr_locate_sequencer

Overview:
- Top-level controller for the finder-pattern locate pipeline. Runs once per captured frame.
- On each frame it resets the cross-pattern finder, starts the horizontal and vertical pattern scanners, then starts the cross finder. It collects the three finder centres, orders them into corner / top-right / bottom-left and reports the result, or a failure on timeout.
- Sits between frame capture (frame_ready) and QR sampling/decoding.

Parameters:
- TIMEOUT_CYCLES, 2000000, cycle budget from scanner start to centres_valid; exceeding it flags failure.
- COORD_W, 9, width of each x/y coordinate.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-low reset
- frame_ready  input  1  1-cycle pulse: new frame is resident in BRAM
- abort_in  input  1  synchronous abort request, level-sampled
- horz_done  input  1  1-cycle pulse from horizontal pattern scanner
- vert_done  input  1  1-cycle pulse from vertical pattern scanner
- centers_valid  input  1  1-cycle pulse from cross finder
- centers_x  input  3xCOORD_W  finder centre x, entries 0..2
- centers_y  input  3xCOORD_W  finder centre y, entries 0..2
- finder_rst  output  1  active-high synchronous reset to scanners and cross finder
- start_horz  output  1  1-cycle start pulse
- start_vert  output  1  1-cycle start pulse
- start_cross  output  1  1-cycle start pulse
- busy  output  1  high in every state except IDLE
- locate_valid  output  1  1-cycle pulse: corner/right/bottom outputs updated
- locate_fail  output  1  1-cycle pulse on timeout
- corner_x, corner_y, right_x, right_y, bottom_x, bottom_y  output  COORD_W each  ordered centres, held until next locate_valid

Behaviour:
- Reset (rst_in low, asynchronous): state=IDLE. All outputs 0, all coordinate outputs 0, timer 0, done latches 0.
- IDLE: on frame_ready go to PREP. No other input has any effect.
- PREP (1 cycle): finder_rst=1. Clear horz/vert done latches. Clear timer. Next state SCAN.
- SCAN: start_horz and start_vert are high only on the first SCAN cycle. horz_done and vert_done are latched independently and may arrive in either order or together. A done pulse arriving in the same cycle as the start pulses is latched. When both latches are set, go to CROSS.
- CROSS: start_cross is high only on the first CROSS cycle. On centers_valid, capture all six coordinates and go to SORT.
- Timer: increments every cycle in SCAN and CROSS and is not cleared between them. When timer==TIMEOUT_CYCLES-1 and the cycle's advancing event is absent, go to FAIL. The advancing event is both latches set in SCAN, or centers_valid in CROSS. If the advancing event and the timeout coincide, the advancing event wins.
- SORT (1 cycle), computed on the captured values:
  - Pairwise Manhattan distances d01, d02, d12, each COORD_W+1 bits unsigned.
  - Longest side selected with tie priority d12 > d02 > d01.
  - Corner = the index not in the longest pair.
  - Of the remaining two, right = smaller y, bottom = the other. If y is equal, right = smaller x. If x is also equal, right = lower index.
  - Register the results to the outputs at the end of SORT.
- DONE (1 cycle): locate_valid=1, then go to IDLE.
- FAIL (1 cycle): locate_fail=1 and finder_rst=1. Coordinate outputs are unchanged. Then go to IDLE.
- abort_in high in PREP/SCAN/CROSS: next state IDLE with finder_rst=1 for that transition cycle. No fail pulse. abort_in is ignored in IDLE, SORT, DONE and FAIL.
- frame_ready while busy: ignored (dropped). It is not queued.
- Unexpected done or centers_valid pulses in any other state: ignored.
- Latency from frame_ready to start pulses: 2 cycles (PREP, then first SCAN cycle). Latency from centers_valid to locate_valid: 2 cycles.
- Reset asserted mid-operation: immediate return to the reset values. No pulses are emitted.

Optional Feature:
- Macro LOCATE_STATS_EN.
- When defined, add three 16-bit outputs: stat_ok, stat_fail, stat_drop.
  - stat_ok increments on locate_valid.
  - stat_fail increments on locate_fail.
  - stat_drop increments on frame_ready while busy.
  - All three saturate at 16'hFFFF and reset to 0.
  - Add input stat_clr (synchronous). It zeroes all three; if it coincides with an increment event, the zero wins.
- When undefined, these ports and counters are absent and the behaviour is otherwise identical.

Test Plan:
- Nominal flow: frame_ready, then horz_done 5 cycles after start and vert_done 9 cycles after start, centers_valid with x={100,300,100}, y={100,100,300} → finder_rst one cycle, single start pulses, locate_valid with corner=(100,100), right=(300,100), bottom=(100,300).
- Ordering and ties: centres x={50,50,250}, y={250,50,50} → corner=(50,50), right=(250,50), bottom=(50,250). Also all three centres at (10,10) → corner=idx0 (per the d12 tie priority), right=idx1, bottom=idx2.
- Timeout with TIMEOUT_CYCLES=20: horz_done only, vert_done never arrives → locate_fail exactly 20 cycles after SCAN entry, finder_rst high in that cycle, coordinate outputs unchanged. Repeat with centers_valid on the final budget cycle → locate_valid, no fail.
- Simultaneous and early events: horz_done and vert_done in the same cycle as the start pulses → CROSS entered the next cycle. frame_ready during CROSS → ignored; with LOCATE_STATS_EN, stat_drop=1.
- Abort and reset: abort_in in CROSS → IDLE with finder_rst pulse, no locate_fail. rst_in low in SCAN → all outputs 0 immediately, then a new frame_ready runs normally.
